// File: rtl/load_store_unit_pkg.sv
// Shared configuration for the load/store unit: data-memory layout, RV32I
// width codes, FSM encoding, request record and the request fault checks.
package load_store_unit_pkg;

  localparam int          DATA_WIDTH       = 32;
  localparam logic [31:0] BEGINNING_DATA   = 32'h1001_0000;
  localparam int          LSU_READ_LATENCY = 1;

  // funct3 width/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCESS = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  typedef struct packed {
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] data;
  } lsu_req_t;

  // Stores only have B/H/W; loads additionally have BU/HU.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
  endfunction

  // Width is carried in funct3[1:0]; halfwords need addr[0]=0, words addr[1:0]=0.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    if (f3[1:0] == F3_H[1:0]) return a[0];
    if (f3[1])                return a != 2'b00;
    return 1'b0;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane steering for the load/store unit: byte enables, store-data lane
// replication and load-data extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] read_data,
  output logic [3:0]  byte_en,
  output logic [31:0] write_data,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Pick the lane mask and move the addressed lane down to bit 0 for loads.
  always_comb begin
    shifted = read_data >> {addr_lo, 3'b000};
    case (funct3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << addr_lo;
        write_data = {4{store_data[7:0]}};
        load_data  = funct3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        byte_en    = 4'b0011 << addr_lo;
        write_data = {2{store_data[15:0]}};
        load_data  = funct3[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        byte_en    = 4'b1111;
        write_data = store_data;
        load_data  = shifted;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store bus initiator: latches one request, drives the data-memory
// strobes, waits out the read latency and returns extended load data.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int READ_LATENCY = LSU_READ_LATENCY
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic        iIsStore,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddress,
  input  logic [31:0] iStoreData,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oLoadData,
  output logic        oMisaligned,
  output logic        oIllegal,
  output logic        oReadEnable,
  output logic        oWriteEnable,
  output logic [3:0]  oByteEnable,
  output logic [31:0] oAddress,
  output logic [31:0] oWriteData,
  input  logic [31:0] iReadData
);

  logic [2:0]  state;
  lsu_req_t    req;
  logic [3:0]  cnt;
  logic        mis_q, ill_q;
  logic        mis_in, ill_in;
  logic [3:0]  be;
  logic [31:0] wd, ld;

  assign ill_in = f3_illegal(iIsStore, iFunct3);
  assign mis_in = f3_misaligned(iFunct3, iAddress[1:0]);

  lsu_align u_align (
    .funct3     (req.funct3),
    .addr_lo    (req.addr[1:0]),
    .store_data (req.data),
    .read_data  (iReadData),
    .byte_en    (be),
    .write_data (wd),
    .load_data  (ld)
  );

  // Request FSM; counter reloads in ACCESS and hands over to DONE at 1.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= S_IDLE;
      req       <= '0;
      cnt       <= '0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
      oLoadData <= '0;
    end else begin
      case (state)
        S_IDLE: if (iStart) begin
          req   <= '{is_store: iIsStore, funct3: iFunct3, addr: iAddress, data: iStoreData};
          mis_q <= mis_in;
          ill_q <= ill_in;
          state <= (mis_in || ill_in) ? S_FAULT : S_ACCESS;
        end
        S_ACCESS: if (req.is_store) begin
          state <= S_DONE;
        end else begin
          cnt   <= 4'(READ_LATENCY);
          state <= S_WAIT;
        end
        S_WAIT: if (cnt == 4'd1) begin
          oLoadData <= ld;
          state     <= S_DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus outputs decode from state only, so reset clears them without a clock
  // and iStart has no combinational route onto the bus.
  assign oWriteEnable = (state == S_ACCESS) && req.is_store;
  assign oReadEnable  = ((state == S_ACCESS) && !req.is_store) || (state == S_WAIT);
  assign oByteEnable  = (oReadEnable || oWriteEnable) ? be : 4'b0000;
  assign oWriteData   = oWriteEnable ? wd : 32'h0;
  assign oAddress     = req.addr;
  assign oBusy        = (state != S_IDLE);
  assign oDone        = (state == S_DONE) || (state == S_FAULT);
  assign oMisaligned  = (state == S_FAULT) && mis_q;
  assign oIllegal     = (state == S_FAULT) && ill_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: two instances (read latency 1 and 3) share one input
// stream; a directed table, hand sequences and random requests are checked
// against an arithmetic reference model.
module tb_load_store_unit;

  localparam int RLS [2] = '{1, 3};

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a, sd, rd;
    logic        mis, ill;
    logic [3:0]  be;
    logic [31:0] wd, ld;
  } vec_t;

  typedef struct {
    int          done_cyc, ndone, we_n, re_n;
    logic        mis, ill, unstable, busy_end;
    logic [3:0]  be;
    logic [31:0] wd, ld, addr;
  } obs_t;

  logic        iCLK = 1'b0, iRST = 1'b1, iStart = 1'b0, iIsStore = 1'b0;
  logic [2:0]  iFunct3 = '0;
  logic [31:0] iAddress = '0, iStoreData = '0, iReadData = '0;

  logic        busy [2], done [2], mis [2], ill [2], re [2], we [2];
  logic [3:0]  be [2];
  logic [31:0] ld [2], addr [2], wd [2];

  int   checks = 0, failures = 0;
  obs_t obs [2];
  logic [31:0] held = '0;
  vec_t tab [12];
  vec_t e;

  always #5 iCLK = ~iCLK;

  load_store_unit #(.READ_LATENCY(1)) dut1 (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iIsStore(iIsStore), .iFunct3(iFunct3),
    .iAddress(iAddress), .iStoreData(iStoreData), .oBusy(busy[0]), .oDone(done[0]),
    .oLoadData(ld[0]), .oMisaligned(mis[0]), .oIllegal(ill[0]), .oReadEnable(re[0]),
    .oWriteEnable(we[0]), .oByteEnable(be[0]), .oAddress(addr[0]), .oWriteData(wd[0]),
    .iReadData(iReadData));

  load_store_unit #(.READ_LATENCY(3)) dut3 (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iIsStore(iIsStore), .iFunct3(iFunct3),
    .iAddress(iAddress), .iStoreData(iStoreData), .oBusy(busy[1]), .oDone(done[1]),
    .oLoadData(ld[1]), .oMisaligned(mis[1]), .oIllegal(ill[1]), .oReadEnable(re[1]),
    .oWriteEnable(we[1]), .oByteEnable(be[1]), .oAddress(addr[1]), .oWriteData(wd[1]),
    .iReadData(iReadData));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on widths and shifts.
  function automatic vec_t mdl(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] sd, input logic [31:0] rd, input logic [31:0] hold);
    vec_t   r;
    int     bits, off;
    longint v;
    bits = (f3[1:0] == 2'd0) ? 8 : (f3[1:0] == 2'd1) ? 16 : 32;
    off  = int'(a % 4);
    r.st = st; r.f3 = f3; r.a = a; r.sd = sd; r.rd = rd;
    r.ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    r.mis = (bits == 16 && (a % 2) != 0) || (bits == 32 && off != 0);
    r.be  = (bits == 8) ? 4'(1 << off) : (bits == 16) ? 4'(3 << off) : 4'hF;
    r.wd  = (bits == 8) ? sd[7:0] * 32'h0101_0101 : (bits == 16) ? sd[15:0] * 32'h0001_0001 : sd;
    v = longint'(rd) >> (8 * off);
    v = v & ((64'd1 << bits) - 1);
    if (!f3[2] && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    r.ld = (st || r.mis || r.ill) ? hold : v[31:0];
    return r;
  endfunction

  // One request into both instances; record every strobe and response seen.
  task automatic run_txn(input vec_t v, input int poke);
    @(posedge iCLK); #1;
    iIsStore = v.st; iFunct3 = v.f3; iAddress = v.a; iStoreData = v.sd; iReadData = v.rd;
    iStart = 1'b1;
    for (int d = 0; d < 2; d++) obs[d] = '{done_cyc: -1, default: 0};
    @(posedge iCLK); #1;
    iStart = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == poke) begin iStart = 1'b1; iIsStore = 1'b1; end
      else iStart = 1'b0;
      @(negedge iCLK);
      for (int d = 0; d < 2; d++) begin
        if (done[d]) begin
          obs[d].ndone++;
          if (obs[d].done_cyc < 0) begin
            obs[d].done_cyc = c; obs[d].mis = mis[d]; obs[d].ill = ill[d];
          end
        end
        if (we[d]) begin obs[d].we_n++; obs[d].wd = wd[d]; end
        if (re[d]) obs[d].re_n++;
        if (re[d] || we[d]) begin
          if (obs[d].re_n + obs[d].we_n == 1) begin obs[d].be = be[d]; obs[d].addr = addr[d]; end
          else if (be[d] !== obs[d].be || addr[d] !== obs[d].addr) obs[d].unstable = 1'b1;
        end
      end
      @(posedge iCLK); #1;
    end
    iStart = 1'b0;
    for (int d = 0; d < 2; d++) begin obs[d].ld = ld[d]; obs[d].busy_end = busy[d]; end
  endtask

  task automatic check_obs(input string nm, input vec_t x);
    logic flt;
    int   exp_done;
    flt = x.mis || x.ill;
    for (int d = 0; d < 2; d++) begin
      exp_done = flt ? 1 : x.st ? 2 : 2 + RLS[d];
      chk($sformatf("%s rl%0d done_cycle", nm, RLS[d]), 32'(obs[d].done_cyc), 32'(exp_done));
      chk($sformatf("%s rl%0d done_count", nm, RLS[d]), 32'(obs[d].ndone), 32'd1);
      chk($sformatf("%s rl%0d illegal", nm, RLS[d]), 32'(obs[d].ill), 32'(x.ill));
      if (!x.ill) chk($sformatf("%s rl%0d misaligned", nm, RLS[d]), 32'(obs[d].mis), 32'(x.mis));
      chk($sformatf("%s rl%0d load_data", nm, RLS[d]), obs[d].ld, x.ld);
      chk($sformatf("%s rl%0d we_cycles", nm, RLS[d]), 32'(obs[d].we_n), 32'(!flt && x.st));
      chk($sformatf("%s rl%0d re_cycles", nm, RLS[d]), 32'(obs[d].re_n),
          (!flt && !x.st) ? 32'(1 + RLS[d]) : 32'd0);
      chk($sformatf("%s rl%0d busy_after", nm, RLS[d]), 32'(obs[d].busy_end), 32'd0);
      if (!flt) begin
        chk($sformatf("%s rl%0d byte_en", nm, RLS[d]), 32'(obs[d].be), 32'(x.be));
        chk($sformatf("%s rl%0d bus_addr", nm, RLS[d]), obs[d].addr, x.a);
        chk($sformatf("%s rl%0d bus_stable", nm, RLS[d]), 32'(obs[d].unstable), 32'd0);
        if (x.st) chk($sformatf("%s rl%0d write_data", nm, RLS[d]), obs[d].wd, x.wd);
      end
    end
  endtask

  initial begin
    //           st    f3      addr          sdata         rdata         mis   ill   be       wdata         load
    tab[0]  = '{1'b1, 3'b000, 32'h1001_0003, 32'h0000_00A5, 32'h0,        1'b0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    tab[1]  = '{1'b0, 3'b000, 32'h1001_0001, 32'h0,         32'h0000_80FF, 1'b0, 1'b0, 4'b0010, 32'h0,         32'hFFFF_FF80};
    tab[2]  = '{1'b0, 3'b100, 32'h1001_0001, 32'h0,         32'h0000_80FF, 1'b0, 1'b0, 4'b0010, 32'h0,         32'h0000_0080};
    tab[3]  = '{1'b0, 3'b001, 32'h1001_0002, 32'h0,         32'h7FFF_1234, 1'b0, 1'b0, 4'b1100, 32'h0,         32'h0000_7FFF};
    tab[4]  = '{1'b0, 3'b010, 32'h1001_0006, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0, 4'b0000, 32'h0,         32'h0000_7FFF};
    tab[5]  = '{1'b1, 3'b100, 32'h1001_0000, 32'h1111_2222, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,         32'h0000_7FFF};
    tab[6]  = '{1'b0, 3'b010, 32'h1001_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    tab[7]  = '{1'b1, 3'b001, 32'h1001_0002, 32'h1234_ABCD, 32'h0,        1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'hDEAD_BEEF};
    tab[8]  = '{1'b0, 3'b101, 32'h1001_0000, 32'h0,         32'h0000_F00D, 1'b0, 1'b0, 4'b0011, 32'h0,         32'h0000_F00D};
    tab[9]  = '{1'b0, 3'b001, 32'h1001_0000, 32'h0,         32'h0000_F00D, 1'b0, 1'b0, 4'b0011, 32'h0,         32'hFFFF_F00D};
    tab[10] = '{1'b0, 3'b001, 32'h1001_0003, 32'h0,         32'h0000_F00D, 1'b1, 1'b0, 4'b0000, 32'h0,         32'hFFFF_F00D};
    tab[11] = '{1'b0, 3'b011, 32'h1001_0000, 32'h0,         32'h0000_F00D, 1'b0, 1'b1, 4'b0000, 32'h0,         32'hFFFF_F00D};

    // Outputs while reset is held
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset rl%0d ctl", RLS[d]),
          32'({busy[d], done[d], mis[d], ill[d], re[d], we[d], be[d]}), 32'd0);
      chk($sformatf("reset rl%0d load_data", RLS[d]), ld[d], 32'd0);
      chk($sformatf("reset rl%0d addr_wdata", RLS[d]), addr[d] | wd[d], 32'd0);
    end
    @(posedge iCLK); #1 iRST = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_txn(tab[i], 0);
      check_obs($sformatf("tab%0d", i), tab[i]);
    end
    held = tab[11].ld;

    // iStart pulsed (as a store) during a load's WAIT must be ignored
    e = mdl(1'b0, 3'b010, 32'h1001_0004, 32'h0, 32'h1357_9BDF, held);
    run_txn(e, 2);
    check_obs("start_in_wait", e);
    held = e.ld;

    // Asynchronous reset in the middle of WAIT
    @(posedge iCLK); #1;
    iIsStore = 1'b0; iFunct3 = 3'b010; iAddress = 32'h1001_000C; iReadData = 32'h2468_ACE0;
    iStart = 1'b1;
    @(posedge iCLK); #1 iStart = 1'b0;
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    chk("midwait rl3 re_before_reset", 32'(re[1]), 32'd1);
    #1 iRST = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("midwait rl%0d re_after_reset", RLS[d]), 32'(re[d]), 32'd0);
      chk($sformatf("midwait rl%0d busy_after_reset", RLS[d]), 32'(busy[d]), 32'd0);
      chk($sformatf("midwait rl%0d load_after_reset", RLS[d]), ld[d], 32'd0);
    end
    @(posedge iCLK); #1 iRST = 1'b0;
    held = 32'h0;
    e = mdl(1'b0, 3'b000, 32'h1001_0002, 32'h0, 32'h0080_0000, held);
    run_txn(e, 0);
    check_obs("after_reset", e);
    held = e.ld;

    // Random requests
    for (int i = 0; i < 40; i++) begin
      e = mdl(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              32'h1001_0000 | 32'($urandom_range(0, 255)), $urandom, $urandom, held);
      run_txn(e, 0);
      check_obs($sformatf("rnd%0d", i), e);
      held = e.ld;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
